// File: rtl/inequality_pkg.sv
// Shared constants and types for the inequality threshold classifier.
package inequality_pkg;

  localparam int unsigned DEF_GT_HI  = 7;
  localparam int unsigned DEF_GE_TOP = 12;
  localparam int unsigned DEF_LT_LO  = 4;

  localparam int unsigned IDX_GT = 2;
  localparam int unsigned IDX_GE = 1;
  localparam int unsigned IDX_LT = 0;

  typedef logic [2:0] flags_t;

  typedef enum logic [1:0] {
    CMP_GT = 2'd0,
    CMP_GE = 2'd1,
    CMP_LT = 2'd2
  } cmp_op_e;

endpackage

// File: rtl/inequality_cmp.sv
// Single unsigned comparator of an operand against a fixed threshold.
module ineq_cmp
  import inequality_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter cmp_op_e     OP  = CMP_GT,
  parameter logic [W-1:0] THR = '0
) (
  input  logic [W-1:0] a_i,
  output logic         hit_o
);

  always_comb begin
    hit_o = 1'b0;
    case (OP)
      CMP_GT:  hit_o = (a_i >  THR);
      CMP_GE:  hit_o = (a_i >= THR);
      CMP_LT:  hit_o = (a_i <  THR);
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/inequality.sv
// Registered three-way threshold classifier: OUT = {NUM>GT_HI, NUM>=GE_TOP, NUM<LT_LO}.
module inequality
  import inequality_pkg::*;
#(
  parameter int unsigned W      = 4,
  parameter int unsigned GT_HI  = DEF_GT_HI,
  parameter int unsigned GE_TOP = DEF_GE_TOP,
  parameter int unsigned LT_LO  = DEF_LT_LO
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] NUM,
  output logic         out_valid,
  output logic [2:0]   OUT
);

  if ((GT_HI >= (1 << W)) || (GE_TOP >= (1 << W)) || (LT_LO >= (1 << W))) begin : g_thr_range
    $error("inequality: thresholds must fit in W bits");
  end

  localparam logic [W-1:0] GT_T = W'(GT_HI);
  localparam logic [W-1:0] GE_T = W'(GE_TOP);
  localparam logic [W-1:0] LT_T = W'(LT_LO);

  flags_t flags;
  flags_t out_d, out_q;
  logic   vld_d, vld_q;

  ineq_cmp #(.W(W), .OP(CMP_GT), .THR(GT_T)) u_gt (.a_i(NUM), .hit_o(flags[IDX_GT]));
  ineq_cmp #(.W(W), .OP(CMP_GE), .THR(GE_T)) u_ge (.a_i(NUM), .hit_o(flags[IDX_GE]));
  ineq_cmp #(.W(W), .OP(CMP_LT), .THR(LT_T)) u_lt (.a_i(NUM), .hit_o(flags[IDX_LT]));

  // Select rather than gate so NUM (possibly X) never reaches the register when idle.
  always_comb begin
    out_d = out_q;
    vld_d = in_valid;
    if (in_valid) out_d = flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign OUT       = out_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_inequality.sv
// Directed self-checking bench for the inequality classifier.
module tb_inequality;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] NUM;
  logic       out_valid;
  logic [2:0] OUT;

  int pass_cnt  = 0;
  int total_cnt = 0;

  inequality #(.W(4), .GT_HI(7), .GE_TOP(12), .LT_LO(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .NUM      (NUM),
    .out_valid(out_valid),
    .OUT      (OUT)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    NUM = 4'd14; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (OUT !== 3'b000 || out_valid !== 1'b0)
      $display("FAIL reset_async: OUT=%b vld=%b, want OUT=000 vld=0", OUT, out_valid);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (OUT !== 3'b000 || out_valid !== 1'b0)
        $display("FAIL reset_hold%0d: OUT=%b vld=%b, want OUT=000 vld=0", i, OUT, out_valid);
      else pass_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    NUM = 4'd14; in_valid = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (OUT !== 3'b110 || out_valid !== 1'b1)
      $display("FAIL single_14: OUT=%b vld=%b, want OUT=110 vld=1", OUT, out_valid);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_sweep();
    logic [2:0] tbl [4];
    tbl[0] = 3'b001; tbl[1] = 3'b000; tbl[2] = 3'b100; tbl[3] = 3'b110;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      NUM = 4'(i); in_valid = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (OUT !== tbl[i / 4] || out_valid !== 1'b1)
        $display("FAIL sweep_%0d: OUT=%b vld=%b, want OUT=%b vld=1", i, OUT, out_valid, tbl[i / 4]);
      else pass_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_boundaries();
    logic [3:0] nums [6];
    logic [2:0] exps [6];
    nums[0] = 4'd7;  exps[0] = 3'b000;
    nums[1] = 4'd8;  exps[1] = 3'b100;
    nums[2] = 4'd11; exps[2] = 3'b100;
    nums[3] = 4'd12; exps[3] = 3'b110;
    nums[4] = 4'd3;  exps[4] = 3'b001;
    nums[5] = 4'd4;  exps[5] = 3'b000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      NUM = nums[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (OUT !== exps[i] || out_valid !== 1'b1)
        $display("FAIL bound_%0d: OUT=%b vld=%b, want OUT=%b vld=1", nums[i], OUT, out_valid, exps[i]);
      else pass_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_hold();
    @(negedge clk);
    NUM = 4'd14; in_valid = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (OUT !== 3'b110 || out_valid !== 1'b1)
      $display("FAIL hold_load: OUT=%b vld=%b, want OUT=110 vld=1", OUT, out_valid);
    else pass_cnt++;
    @(negedge clk);
    NUM = 4'd0; in_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (OUT !== 3'b110 || out_valid !== 1'b0)
      $display("FAIL hold_zero: OUT=%b vld=%b, want OUT=110 vld=0", OUT, out_valid);
    else pass_cnt++;
    @(negedge clk);
    NUM = 4'bxxxx;
    @(posedge clk); #1;
    total_cnt++;
    if (OUT !== 3'b110 || out_valid !== 1'b0)
      $display("FAIL hold_x: OUT=%b vld=%b, want OUT=110 vld=0", OUT, out_valid);
    else pass_cnt++;
    @(negedge clk);
    NUM = 4'd0;
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    NUM = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (OUT !== 3'b001 || out_valid !== 1'b1)
      $display("FAIL mid_load: OUT=%b vld=%b, want OUT=001 vld=1", OUT, out_valid);
    else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (OUT !== 3'b000 || out_valid !== 1'b0)
      $display("FAIL mid_rst: OUT=%b vld=%b, want OUT=000 vld=0", OUT, out_valid);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (OUT !== 3'b000 || out_valid !== 1'b0)
        $display("FAIL mid_after%0d: OUT=%b vld=%b, want OUT=000 vld=0", i, OUT, out_valid);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; NUM = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_sweep();
    test_boundaries();
    test_hold();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
